stream_return_router: RTL and testbench

//  Return-direction router for the streaming crossbar: routes packets from M_DATA_COUNT

---
 rtl/stream_return_router.sv | 221 ++++++++++++++++++++++
 tb/tb_stream_return_router.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_return_router.sv
// -----------------------------------------------------------------------------
// stream_return_router
//
// Return-direction router for the streaming crossbar. Beats arriving on the
// M_DATA_COUNT return inputs are steered back to one of S_DATA_COUNT outputs by
// their T_ID tag. Every output owns a packet-locked round-robin arbiter and a
// single output register stage, so packets are never interleaved on an output
// and different outputs run fully in parallel. Each output also reports which
// input the current packet came from.
//
// Beats whose id does not name an existing output are accepted and dropped so
// that a misconfigured source can never stall.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   m_data_i   input payload, input i at [i*T_DATA_WIDTH +: T_DATA_WIDTH]
//   m_id_i     target output index per input
//   m_valid_i  input beat valid
//   m_last_i   input beat is the last of its packet
//   m_ready_o  input beat accepted when valid & ready
//   s_data_o   output payload
//   s_dest_o   index of the input the current packet came from
//   s_valid_o  output beat valid
//   s_last_o   output beat is the last of its packet
//   s_ready_i  downstream ready
// -----------------------------------------------------------------------------
module stream_return_router #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 3,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_i,
  input  logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_i,
  input  logic [M_DATA_COUNT-1:0]              m_valid_i,
  input  logic [M_DATA_COUNT-1:0]              m_last_i,
  output logic [M_DATA_COUNT-1:0]              m_ready_o,
  output logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_o,
  output logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_o,
  output logic [S_DATA_COUNT-1:0]              s_valid_o,
  output logic [S_DATA_COUNT-1:0]              s_last_o,
  input  logic [S_DATA_COUNT-1:0]              s_ready_i
);

  // Width of an input index held inside the arbiters.
  localparam int IDX_W = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1;

  // Per-output arbiter states.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]              state_q [S_DATA_COUNT];
  logic [IDX_W-1:0]        grant_q [S_DATA_COUNT];
  logic [IDX_W-1:0]        ptr_q   [S_DATA_COUNT];
  logic [T_DATA_WIDTH-1:0] data_q  [S_DATA_COUNT];
  logic [T_DEST_WIDTH-1:0] dest_q  [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] valid_q;
  logic [S_DATA_COUNT-1:0] last_q;

  // ---------------------------------------------------------------------------
  // Input unpacking
  // ---------------------------------------------------------------------------
  logic [T_ID___WIDTH-1:0] id_w   [M_DATA_COUNT];
  logic [T_DATA_WIDTH-1:0] data_w [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] id_ok;

  always_comb begin
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      id_w[i]   = m_id_i[i*T_ID___WIDTH +: T_ID___WIDTH];
      data_w[i] = m_data_i[i*T_DATA_WIDTH +: T_DATA_WIDTH];
      id_ok[i]  = (int'(id_w[i]) < S_DATA_COUNT);
    end
  end

  // An output register can take a new beat when it is empty or draining.
  logic [S_DATA_COUNT-1:0] out_free;
  assign out_free = ~valid_q | s_ready_i;

  // ---------------------------------------------------------------------------
  // Ownership: which inputs are locked to an output, and their ready.
  // ---------------------------------------------------------------------------
  logic [M_DATA_COUNT-1:0] busy;
  logic [M_DATA_COUNT-1:0] ready_raw;

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment; a path that leaves it unassigned infers a latch.
  always_comb begin
    busy      = '0;
    ready_raw = '0;
    for (int j = 0; j < S_DATA_COUNT; j++) begin
      for (int i = 0; i < M_DATA_COUNT; i++) begin
        if (state_q[j] == ST_LOCKED && grant_q[j] == IDX_W'(i)) begin
          busy[i]      = 1'b1;
          ready_raw[i] = out_free[j];
        end
      end
    end
    // Unroutable beats are swallowed so the source keeps moving.
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      if (!busy[i] && !id_ok[i]) begin
        ready_raw[i] = 1'b1;
      end
    end
  end

  // The invalid-id path is purely combinational, so hold ready low while the
  // block is in reset to keep sources from handing over beats that vanish.
  assign m_ready_o = ready_raw & {M_DATA_COUNT{rst_n}};

  // ---------------------------------------------------------------------------
  // Requests, round-robin selection and beat acceptance per output
  // ---------------------------------------------------------------------------
  logic [M_DATA_COUNT-1:0] req    [S_DATA_COUNT];
  logic [IDX_W-1:0]        sel    [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] any_req;
  logic [S_DATA_COUNT-1:0] accept;
  logic [S_DATA_COUNT-1:0] acc_last;

  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    any_req  = '0;
    accept   = '0;
    acc_last = '0;
    for (int j = 0; j < S_DATA_COUNT; j++) begin
      // An input already locked to some output is not a new requester, so its
      // id is ignored until its packet ends.
      for (int i = 0; i < M_DATA_COUNT; i++) begin
        req[j][i] = m_valid_i[i] && !busy[i] && (id_w[i] == T_ID___WIDTH'(j));
      end
      any_req[j] = |req[j];

      // First requester strictly after the pointer, searching upward with
      // wrap; the pointer itself is visited last.
      sel[j] = ptr_q[j];
      found  = 1'b0;
      for (int k = 1; k <= M_DATA_COUNT; k++) begin
        idx = (int'(ptr_q[j]) + k) % M_DATA_COUNT;
        if (!found && req[j][idx]) begin
          sel[j] = IDX_W'(idx);
          found  = 1'b1;
        end
      end

      accept[j]   = (state_q[j] == ST_LOCKED) && m_valid_i[grant_q[j]] && out_free[j];
      acc_last[j] = m_last_i[grant_q[j]];
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSMs and output registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        state_q[j] <= ST_IDLE;
        grant_q[j] <= '0;
        // Pointer starts at the highest index so input 0 wins first.
        ptr_q[j]   <= IDX_W'(M_DATA_COUNT - 1);
        // NOTE: the payload registers drive the outputs directly and must read
        // zero out of reset, so they are reset along with the control state.
        data_q[j]  <= '0;
        dest_q[j]  <= '0;
      end
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        case (state_q[j])
          ST_IDLE: begin
            // Grant only; the first beat is taken on the following cycle.
            if (any_req[j]) begin
              grant_q[j] <= sel[j];
              state_q[j] <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (accept[j] && acc_last[j]) begin
              ptr_q[j]   <= grant_q[j];
              state_q[j] <= ST_IDLE;
            end
          end
          default: state_q[j] <= ST_IDLE;
        endcase

        if (accept[j]) begin
          valid_q[j] <= 1'b1;
          last_q[j]  <= acc_last[j];
          data_q[j]  <= data_w[grant_q[j]];
          dest_q[j]  <= T_DEST_WIDTH'(grant_q[j]);
        end else if (s_ready_i[j]) begin
          // Data and last are left as they are; only valid drops.
          valid_q[j] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_out
    assign s_data_o[j*T_DATA_WIDTH +: T_DATA_WIDTH] = data_q[j];
    assign s_dest_o[j*T_DEST_WIDTH +: T_DEST_WIDTH] = dest_q[j];
  end

  assign s_valid_o = valid_q;
  assign s_last_o  = last_q;

endmodule

// File: tb/tb_stream_return_router.sv
// -----------------------------------------------------------------------------
// tb_stream_return_router
//
// Directed scenarios with exact cycle expectations, then a randomized phase.
// Sources are per-input beat queues; a scoreboard holds, for every routable
// beat, its source input, target output, payload and last flag. Each delivered
// output beat must be the oldest outstanding beat of its (input, output) pair,
// packets must not interleave on an output, and a stalled output must hold.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_return_router;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int M  = 3;
  localparam int IW = 2;
  localparam int DW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W*M-1:0]   m_data_i;
  logic [IW*M-1:0]  m_id_i;
  logic [M-1:0]     m_valid_i;
  logic [M-1:0]     m_last_i;
  logic [M-1:0]     m_ready_o;
  logic [W*S-1:0]   s_data_o;
  logic [DW*S-1:0]  s_dest_o;
  logic [S-1:0]     s_valid_o;
  logic [S-1:0]     s_last_o;
  logic [S-1:0]     s_ready_i;

  always #5 clk = ~clk;

  stream_return_router #(
    .T_DATA_WIDTH (W),
    .S_DATA_COUNT (S),
    .M_DATA_COUNT (M),
    .T_ID___WIDTH (IW),
    .T_DEST_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_data_i  (m_data_i),
    .m_id_i    (m_id_i),
    .m_valid_i (m_valid_i),
    .m_last_i  (m_last_i),
    .m_ready_o (m_ready_o),
    .s_data_o  (s_data_o),
    .s_dest_o  (s_dest_o),
    .s_valid_o (s_valid_o),
    .s_last_o  (s_last_o),
    .s_ready_i (s_ready_i)
  );

  typedef struct { int inp; int id; logic [W-1:0] data; logic last; } sbeat_t;
  typedef struct { int src; int dst; logic [W-1:0] data; logic last; } ebeat_t;
  typedef struct { int cyc; int port; int src; logic [W-1:0] data; logic last; } obeat_t;

  sbeat_t src_q[$];
  ebeat_t exp_q[$];
  obeat_t log_q[$];

  int n_checks;
  int n_err;
  int cyc;
  int t0;
  int gap_pct;

  logic [M-1:0]   present;
  logic [M-1:0]   mr_s;
  logic [S-1:0]   hold;
  logic [W-1:0]   hold_data [S];
  logic           hold_last [S];
  logic [DW-1:0]  hold_dest [S];
  logic [S-1:0]   in_pkt;
  int             cur_src [S];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int find_head(input int i);
    for (int k = 0; k < src_q.size(); k++)
      if (src_q[k].inp == i) return k;
    return -1;
  endfunction

  // Queue one packet on input i; routable beats also go to the scoreboard.
  task automatic send_pkt(input int i, input int id, input int len);
    sbeat_t b;
    ebeat_t e;
    for (int k = 0; k < len; k++) begin
      b.inp  = i;
      b.id   = id;
      b.data = W'($urandom);
      b.last = (k == len - 1);
      src_q.push_back(b);
      if (id < S) begin
        e.src = i; e.dst = id; e.data = b.data; e.last = b.last;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic sample_output(input int j);
    int           d;
    int           k;
    logic [W-1:0] dat;
    logic         lst;
    obeat_t       o;
    dat = s_data_o[j*W +: W];
    lst = s_last_o[j];
    d   = int'(s_dest_o[j*DW +: DW]);
    if (hold[j]) begin
      check($sformatf("hold_valid_o%0d", j), s_valid_o[j], 1);
      check($sformatf("hold_data_o%0d", j), dat, hold_data[j]);
      check($sformatf("hold_last_o%0d", j), lst, hold_last[j]);
      check($sformatf("hold_dest_o%0d", j), d, hold_dest[j]);
    end
    hold[j]      = s_valid_o[j] && !s_ready_i[j];
    hold_data[j] = dat;
    hold_last[j] = lst;
    hold_dest[j] = DW'(d);
    if (s_valid_o[j] && s_ready_i[j]) begin
      o.cyc = cyc; o.port = j; o.src = d; o.data = dat; o.last = lst;
      log_q.push_back(o);
      if (in_pkt[j]) check($sformatf("no_interleave_o%0d", j), d, cur_src[j]);
      k = -1;
      for (int x = 0; x < exp_q.size(); x++) begin
        if (k < 0 && exp_q[x].src == d && exp_q[x].dst == j) k = x;
      end
      check($sformatf("beat_expected_o%0d_src%0d", j, d), k >= 0, 1);
      if (k >= 0) begin
        check($sformatf("data_o%0d_src%0d", j, d), dat, exp_q[k].data);
        check($sformatf("last_o%0d_src%0d", j, d), lst, exp_q[k].last);
        exp_q.delete(k);
      end
      in_pkt[j]  = !lst;
      cur_src[j] = d;
    end
  endtask

  // One clock cycle: drive source heads, sample at the falling edge, retire
  // accepted beats after the rising edge.
  task automatic run_cycle();
    int         h;
    logic [M-1:0] acc;
    for (int i = 0; i < M; i++) begin
      h = find_head(i);
      if (h < 0) begin
        m_valid_i[i]          = 1'b0;
        m_last_i[i]           = 1'b0;
        m_id_i[i*IW +: IW]    = '0;
        m_data_i[i*W +: W]    = '0;
      end else begin
        m_valid_i[i]          = present[i] || ($urandom_range(99) >= gap_pct);
        m_last_i[i]           = src_q[h].last;
        m_id_i[i*IW +: IW]    = IW'(src_q[h].id);
        m_data_i[i*W +: W]    = src_q[h].data;
      end
    end
    @(negedge clk);
    mr_s = m_ready_o;
    acc  = m_valid_i & m_ready_o;
    for (int j = 0; j < S; j++) sample_output(j);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < M; i++) begin
      if (acc[i]) begin
        h = find_head(i);
        if (h >= 0) src_q.delete(h);
        present[i] = 1'b0;
      end else begin
        present[i] = m_valid_i[i];
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    m_valid_i = '0;
    m_last_i  = '0;
    m_id_i    = '0;
    m_data_i  = '0;
    s_ready_i = '1;
    src_q.delete();
    exp_q.delete();
    log_q.delete();
    present = '0;
    hold    = '0;
    in_pkt  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int log_nth(input int port, input int n);
    int c;
    c = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      if (log_q[k].port == port) begin
        if (c == n) return k;
        c++;
      end
    end
    return -1;
  endfunction

  task automatic check_beat(input string tag, input int port, input int n,
                            input int want_cyc, input int want_src, input logic want_last);
    int k;
    k = log_nth(port, n);
    check($sformatf("%s_b%0d_present", tag, n), k >= 0, 1);
    if (k >= 0) begin
      check($sformatf("%s_b%0d_cycle", tag, n), log_q[k].cyc, want_cyc);
      check($sformatf("%s_b%0d_dest", tag, n), log_q[k].src, want_src);
      check($sformatf("%s_b%0d_last", tag, n), log_q[k].last, want_last);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_err = 0; cyc = 0; gap_pct = 0;
    present = '0; hold = '0; in_pkt = '0;

    // Reset state, with every input offering an unroutable beat.
    rst_n     = 1'b0;
    m_valid_i = '1;
    m_id_i    = '1;
    m_last_i  = '0;
    m_data_i  = '1;
    s_ready_i = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_valid", s_valid_o, 0);
    check("rst_s_last", s_last_o, 0);
    check("rst_s_data", s_data_o, 0);
    check("rst_s_dest", s_dest_o, 0);
    check("rst_m_ready", m_ready_o, 0);
    do_reset();

    // 1: three-beat packet input 1 -> output 2, two-cycle latency.
    t0 = cyc;
    send_pkt(1, 2, 3);
    repeat (8) run_cycle();
    check("t1_count", log_q.size(), 3);
    for (int n = 0; n < 3; n++) check_beat("t1", 2, n, t0 + 2 + n, 1, n == 2);

    // 2: inputs 0 and 2 contend for output 0; input 0 first, one bubble.
    log_q.delete();
    t0 = cyc;
    send_pkt(0, 0, 2);
    send_pkt(2, 0, 2);
    repeat (10) run_cycle();
    check_beat("t2", 0, 0, t0 + 2, 0, 1'b0);
    check_beat("t2", 0, 1, t0 + 3, 0, 1'b1);
    check_beat("t2", 0, 2, t0 + 5, 2, 1'b0);
    check_beat("t2", 0, 3, t0 + 6, 2, 1'b1);

    // 3: round robin over single-beat packets to output 1.
    log_q.delete();
    t0 = cyc;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < M; i++) send_pkt(i, 1, 1);
    repeat (16) run_cycle();
    check("t3_count", log_q.size(), 6);
    for (int n = 0; n < 6; n++) check_beat("t3", 1, n, t0 + 2 + 2 * n, n % 3, 1'b1);

    // 4: output 0 stalled for three cycles in the middle of a packet.
    log_q.delete();
    t0 = cyc;
    send_pkt(1, 0, 4);
    for (int c = 0; c < 12; c++) begin
      s_ready_i = '1;
      if (c >= 3 && c <= 5) s_ready_i[0] = 1'b0;
      run_cycle();
      if (c >= 3 && c <= 5) check($sformatf("t4_stall_ready_c%0d", c), mr_s[1], 0);
    end
    s_ready_i = '1;
    check_beat("t4", 0, 0, t0 + 2, 1, 1'b0);
    check_beat("t4", 0, 1, t0 + 6, 1, 1'b0);
    check_beat("t4", 0, 2, t0 + 7, 1, 1'b0);
    check_beat("t4", 0, 3, t0 + 8, 1, 1'b1);

    // 5: two outputs streaming concurrently at full rate.
    log_q.delete();
    t0 = cyc;
    send_pkt(0, 1, 4);
    send_pkt(1, 0, 4);
    repeat (8) run_cycle();
    for (int n = 0; n < 4; n++) begin
      check_beat("t5_o1", 1, n, t0 + 2 + n, 0, n == 3);
      check_beat("t5_o0", 0, n, t0 + 2 + n, 1, n == 3);
    end
    check("t1to5_left", exp_q.size(), 0);

    // 6: reset in the middle of a packet, then a fresh packet.
    do_reset();
    t0 = cyc;
    send_pkt(0, 2, 3);
    repeat (3) run_cycle();
    check("t6_pre_valid", s_valid_o[2], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_s_valid", s_valid_o, 0);
    check("t6_rst_m_ready", m_ready_o, 0);
    do_reset();
    t0 = cyc;
    send_pkt(2, 2, 2);
    repeat (6) run_cycle();
    check("t6_count", log_q.size(), 2);
    check_beat("t6", 2, 0, t0 + 2, 2, 1'b0);
    check_beat("t6", 2, 1, t0 + 3, 2, 1'b1);

    // Unroutable id: accepted immediately and never seen on any output.
    log_q.delete();
    send_pkt(1, 3, 2);
    run_cycle();
    check("inv_ready", mr_s[1], 1);
    repeat (5) run_cycle();
    check("inv_drained", src_q.size(), 0);
    check("inv_no_output", log_q.size(), 0);

    // Randomized traffic with gaps and downstream backpressure.
    do_reset();
    gap_pct = 30;
    for (int p = 0; p < 45; p++)
      send_pkt($urandom_range(M - 1), $urandom_range(S), $urandom_range(4, 1));
    for (int c = 0; c < 4000; c++) begin
      for (int j = 0; j < S; j++) s_ready_i[j] = ($urandom_range(3) != 0);
      run_cycle();
      if (src_q.size() == 0 && exp_q.size() == 0) break;
    end
    s_ready_i = '1;
    check("rand_src_left", src_q.size(), 0);
    check("rand_exp_left", exp_q.size(), 0);
    check("rand_pkt_open", in_pkt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
